ext_pipe: RTL and testbench

EXT_PIPE -- requirements
Module: ext_pipe

---
 rtl/ext_pipe.sv | 87 ++++++++
 tb/tb_ext_pipe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ext_pipe.sv
// Immediate-extension stage feeding a 2-entry in-order buffer with valid/ready handshakes.
// Optional completed-transfer counter on oCount is enabled by defining EXT_PIPE_STAT_EN.
module ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iValid,
  output logic             iReady,
  input  logic [1:0]       iMode,
  input  logic [IN_W-1:0]  iData,
  output logic             oValid,
  input  logic             oReady,
  output logic [OUT_W-1:0] oData
`ifdef EXT_PIPE_STAT_EN
  ,
  output logic [CNT_W-1:0] oCount
`endif
);

  if (OUT_W < IN_W + 2 || CNT_W < 1) begin : gBadParam
    $error("ext_pipe: illegal parameters (need OUT_W >= IN_W+2, CNT_W >= 1)");
  end

  logic [OUT_W-1:0] mem [2];
  logic             rdPtr;
  logic             wrPtr;
  logic [1:0]       occ;
  logic [OUT_W-1:0] sextData;
  logic [OUT_W-1:0] extData;
  logic             push;
  logic             pop;

  // Handshake flags come from occupancy only, so iReady never depends on oReady.
  assign iReady = (occ != 2'd2);
  assign oValid = (occ != 2'd0);
  assign oData  = mem[rdPtr];
  assign push   = iValid && iReady;
  assign pop    = oValid && oReady;

  always_comb begin
    sextData = {{(OUT_W-IN_W){iData[IN_W-1]}}, iData};
    extData  = '0;
    case (iMode)
      2'b00:   extData = {{(OUT_W-IN_W){1'b0}}, iData};
      2'b01:   extData = sextData;
      2'b10:   extData = {iData, {(OUT_W-IN_W){1'b0}}};
      default: extData = sextData << 2;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rdPtr  <= 1'b0;
      wrPtr  <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wrPtr] <= extData;
        wrPtr      <= ~wrPtr;
      end
      if (pop) begin
        rdPtr <= ~rdPtr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef EXT_PIPE_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oCount <= '0;
    end else if (pop) begin
      oCount <= oCount + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
`endif

endmodule

// File: tb/tb_ext_pipe.sv
// Bench for ext_pipe: directed scenarios plus a random phase, all checked against a
// queue-based reference model that extends immediates with plain integer arithmetic.
module tb_ext_pipe;

  logic        clk;
  logic        rst;
  logic        iValid;
  logic        iReady;
  logic [1:0]  iMode;
  logic [15:0] iData;
  logic        oValid;
  logic        oReady;
  logic [31:0] oData;
`ifdef EXT_PIPE_STAT_EN
  logic [3:0]  oCount;
`endif

  int nChecks = 0;
  int nFail   = 0;

  logic [31:0] q[$];
  logic [31:0] outs[$];
  int          popCnt = 0;
  logic        lastPush;

  ext_pipe #(.IN_W(16), .OUT_W(32), .CNT_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .iValid (iValid),
    .iReady (iReady),
    .iMode  (iMode),
    .iData  (iData),
    .oValid (oValid),
    .oReady (oReady),
    .oData  (oData)
`ifdef EXT_PIPE_STAT_EN
    ,
    .oCount (oCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] refExt(input logic [1:0] m, input logic [15:0] d);
    longint s;
    s = d[15] ? longint'(d) - 65536 : longint'(d);
    case (m)
      2'd0:    return 32'(longint'(d));
      2'd1:    return 32'(s);
      2'd2:    return 32'(longint'(d) * 65536);
      default: return 32'(s * 4);
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs mid-cycle against the model, then advance model at the edge.
  task automatic cycle();
    logic pushM;
    logic popM;
    @(negedge clk);
    check("iReady", iReady, q.size() < 2);
    check("oValid", oValid, q.size() > 0);
    if (q.size() > 0) check("oData", oData, q[0]);
`ifdef EXT_PIPE_STAT_EN
    check("oCount", oCount, 4'(popCnt));
`endif
    pushM = iValid && (q.size() < 2);
    popM  = oReady && (q.size() > 0);
    @(posedge clk);
    if (popM) begin
      outs.push_back(q.pop_front());
      popCnt++;
    end
    if (pushM) q.push_back(refExt(iMode, iData));
    lastPush = pushM;
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    #2;
    q.delete();
    popCnt = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] modeExp[4];
  logic [31:0] sent[$];
  logic        accepted;

  initial begin
    modeExp[0] = 32'h0000_8001;
    modeExp[1] = 32'hFFFF_8001;
    modeExp[2] = 32'h8001_0000;
    modeExp[3] = 32'hFFFE_0004;
    rst = 1'b1; iValid = 1'b0; oReady = 1'b1; iData = '0; iMode = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rstIReady", iReady, 1'b1);
    check("rstOValid", oValid, 1'b0);
    check("rstOData", oData, 32'h0);
`ifdef EXT_PIPE_STAT_EN
    check("rstOCount", oCount, 4'h0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Each mode on 0x8001; mode is changed right after accept to show it no longer matters.
    for (int m = 0; m < 4; m++) begin
      iValid = 1'b1; iData = 16'h8001; iMode = 2'(m);
      cycle();
      iValid = 1'b0; iMode = ~2'(m);
      check("modeValid", oValid, 1'b1);
      check("modeRes", oData, modeExp[m]);
      cycle();
    end

    iValid = 1'b1; iData = 16'h0004; iMode = 2'd3;
    cycle();
    iValid = 1'b0;
    check("posBranch", oData, 32'h0000_0010);
    cycle();
    iValid = 1'b1; iData = 16'h0004; iMode = 2'd1;
    cycle();
    iValid = 1'b0;
    check("posSext", oData, 32'h0000_0004);
    cycle();

    // Backpressure: fill, stall, then drain in order.
    outs.delete();
    oReady = 1'b0; iValid = 1'b1; iMode = 2'd0;
    iData = 16'h0001; cycle();
    iData = 16'h0002; cycle();
    iData = 16'h0003; cycle();
    check("bpFullReady", iReady, 1'b0);
    check("bpFullHold", oData, 32'h1);
    oReady = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 10 && !accepted; i++) begin
      cycle();
      if (lastPush) accepted = 1'b1;
    end
    check("bpAccept3", accepted, 1'b1);
    iValid = 1'b0;
    repeat (4) cycle();
    check("bpCount", outs.size(), 3);
    for (int i = 0; i < outs.size() && i < 3; i++) check("bpOrder", outs[i], 32'(i + 1));

    // Streaming: one word per cycle, occupancy held at 1.
    outs.delete(); sent.delete();
    iValid = 1'b1; oReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      iData = 16'($urandom); iMode = 2'($urandom);
      sent.push_back(refExt(iMode, iData));
      cycle();
      check("streamOcc", {oValid, iReady}, 2'b11);
    end
    iValid = 1'b0;
    cycle();
    check("streamCount", outs.size(), 8);
    for (int i = 0; i < outs.size() && i < 8; i++) check("streamOrder", outs[i], sent[i]);

    // Reset with a full buffer.
    oReady = 1'b0; iValid = 1'b1; iMode = 2'd0;
    iData = 16'($urandom); cycle();
    iData = 16'($urandom); cycle();
    iValid = 1'b0;
    check("preRstFull", iReady, 1'b0);
    rst = 1'b1;
    #1;
    check("midRstOValid", oValid, 1'b0);
    check("midRstIReady", iReady, 1'b1);
    check("midRstOData", oData, 32'h0);
`ifdef EXT_PIPE_STAT_EN
    check("midRstOCount", oCount, 4'h0);
`endif
    q.delete();
    popCnt = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    oReady = 1'b1; iValid = 1'b1; iData = 16'h00FF; iMode = 2'd1;
    cycle();
    iValid = 1'b0;
    check("postRstValid", oValid, 1'b1);
    check("postRstData", oData, 32'h0000_00FF);
    cycle();

    // 17 pops from reset; the 4-bit counter wraps to 1.
    doReset();
    iValid = 1'b1; oReady = 1'b1;
    for (int i = 0; i < 17; i++) begin
      iData = 16'($urandom); iMode = 2'($urandom);
      cycle();
    end
    iValid = 1'b0;
    cycle();
    check("popTotal", popCnt, 17);
`ifdef EXT_PIPE_STAT_EN
    check("cntWrap", oCount, 4'h1);
    doReset();
    check("cntRst", oCount, 4'h0);
`endif

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      iValid = 1'($urandom);
      oReady = ($urandom_range(0, 3) != 0);
      iData  = 16'($urandom);
      iMode  = 2'($urandom);
      cycle();
    end
    iValid = 1'b0; oReady = 1'b1;
    repeat (3) cycle();
    check("drainEmpty", oValid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
